// File: rtl/router_pkg.sv
// Shared types and constants for the router packet transmitter.
// Header byte layout is {payload_len, dest_addr}; address 3 is not a router port.
package router_pkg;

    localparam int HDR_W  = 8;
    localparam int LEN_W  = 6;
    localparam int ADDR_W = 2;
    localparam int BUF_DEPTH = 1 << LEN_W;

    localparam logic [ADDR_W-1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HEADER,
        ST_PAYLOAD,
        ST_PARITY,
        ST_GAP
    } state_e;

    typedef struct packed {
        logic [LEN_W-1:0]  len;
        logic [ADDR_W-1:0] addr;
    } header_t;

    function automatic header_t make_header(input logic [LEN_W-1:0]  len,
                                            input logic [ADDR_W-1:0] addr);
        header_t h;
        h.len  = len;
        h.addr = addr;
        return h;
    endfunction

    function automatic logic header_ok(input logic [LEN_W-1:0]  len,
                                       input logic [ADDR_W-1:0] addr);
        return (len != '0) && (addr != ADDR_INVALID);
    endfunction

endpackage

// File: rtl/router_pkt_buf.sv
// Payload staging memory: 64x8, one synchronous write port, one asynchronous read port.
module router_pkt_buf
    import router_pkg::*;
(
    input  logic             clock,
    input  logic             we_i,
    input  logic [LEN_W-1:0] waddr_i,
    input  logic [HDR_W-1:0] wdata_i,
    input  logic [LEN_W-1:0] raddr_i,
    output logic [HDR_W-1:0] rdata_o
);

    logic [HDR_W-1:0] mem_q [BUF_DEPTH];

    // NOTE: storage has no reset; every entry read is written in LOAD first, and
    // leaving it out keeps the array mappable to plain RAM.
    always_ff @(posedge clock) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/router_pkt_tx.sv
// Packet transmitter: buffers a payload, then sends header, payload and XOR parity
// to the router with stall support, followed by a fixed idle gap.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter int GAP_CYCLES = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] dest_addr,
    input  logic [LEN_W-1:0]  payload_len,
    input  logic [HDR_W-1:0]  payload_data,
    input  logic              payload_valid,
    output logic              payload_ready,
    input  logic              busy,
    output logic [HDR_W-1:0]  data_out,
    output logic              pkt_valid,
    output logic              tx_active,
    output logic              done,
    output logic              err
);

    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

    state_e           state_q;
    header_t          header_q;
    logic [HDR_W-1:0] parity_q;
    logic [LEN_W-1:0] count_q;
    logic [LEN_W-1:0] index_q;
    logic [GAP_W-1:0] gap_q;

    logic [HDR_W-1:0] data_out_q;
    logic             pkt_valid_q;
    logic             payload_ready_q;
    logic             tx_active_q;
    logic             done_q;
    logic             err_q;

    logic             buf_we;
    logic [LEN_W-1:0] rd_addr;
    logic [HDR_W-1:0] rd_data;
    logic             last_load;
    logic             last_payload;

    // data_out is registered, so the buffer is read one byte ahead of the index.
    assign buf_we       = (state_q == ST_LOAD) && payload_valid;
    assign rd_addr      = (state_q == ST_PAYLOAD) ? index_q + LEN_W'(1) : '0;
    assign last_load    = (count_q == header_q.len - LEN_W'(1));
    assign last_payload = (index_q == header_q.len - LEN_W'(1));

    router_pkt_buf u_buf (
        .clock   (clock),
        .we_i    (buf_we),
        .waddr_i (count_q),
        .wdata_i (payload_data),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values and the outputs line up with the state they belong to.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            header_q        <= '0;
            parity_q        <= '0;
            count_q         <= '0;
            index_q         <= '0;
            gap_q           <= '0;
            data_out_q      <= '0;
            pkt_valid_q     <= 1'b0;
            payload_ready_q <= 1'b0;
            tx_active_q     <= 1'b0;
            done_q          <= 1'b0;
            err_q           <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (header_ok(payload_len, dest_addr)) begin
                            state_q         <= ST_LOAD;
                            header_q        <= make_header(payload_len, dest_addr);
                            parity_q        <= make_header(payload_len, dest_addr);
                            count_q         <= '0;
                            payload_ready_q <= 1'b1;
                            tx_active_q     <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (payload_valid) begin
                        parity_q <= parity_q ^ payload_data;
                        count_q  <= count_q + LEN_W'(1);
                        if (last_load) begin
                            state_q         <= ST_HEADER;
                            payload_ready_q <= 1'b0;
                            data_out_q      <= header_q;
                            pkt_valid_q     <= 1'b1;
                        end
                    end
                end
                ST_HEADER: begin
                    if (!busy) begin
                        state_q    <= ST_PAYLOAD;
                        index_q    <= '0;
                        data_out_q <= rd_data;
                    end
                end
                ST_PAYLOAD: begin
                    if (!busy) begin
                        if (last_payload) begin
                            state_q     <= ST_PARITY;
                            data_out_q  <= parity_q;
                            pkt_valid_q <= 1'b0;
                        end else begin
                            index_q    <= index_q + LEN_W'(1);
                            data_out_q <= rd_data;
                        end
                    end
                end
                ST_PARITY: begin
                    if (!busy) begin
                        data_out_q <= '0;
                        gap_q      <= '0;
                        if (GAP_CYCLES == 0) begin
                            state_q     <= ST_IDLE;
                            tx_active_q <= 1'b0;
                            done_q      <= 1'b1;
                        end else begin
                            state_q <= ST_GAP;
                        end
                    end
                end
                ST_GAP: begin
                    if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
                        state_q     <= ST_IDLE;
                        tx_active_q <= 1'b0;
                        done_q      <= 1'b1;
                    end else begin
                        gap_q <= gap_q + GAP_W'(1);
                    end
                end
                default: begin
                    state_q         <= ST_IDLE;
                    data_out_q      <= '0;
                    pkt_valid_q     <= 1'b0;
                    payload_ready_q <= 1'b0;
                    tx_active_q     <= 1'b0;
                end
            endcase
        end
    end

    assign data_out      = data_out_q;
    assign pkt_valid     = pkt_valid_q;
    assign payload_ready = payload_ready_q;
    assign tx_active     = tx_active_q;
    assign done          = done_q;
    assign err           = err_q;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Self-checking bench for router_pkt_tx: directed scenarios plus randomized packets
// compared against a byte-list model of the transmitted packet.
module tb_router_pkt_tx;

    localparam int GAP = 3;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] dest_addr;
    logic [5:0] payload_len;
    logic [7:0] payload_data;
    logic       payload_valid;
    logic       busy;
    logic       payload_ready;
    logic [7:0] data_out;
    logic       pkt_valid;
    logic       tx_active;
    logic       done;
    logic       err;

    int vectors = 0;
    int miscompares = 0;

    logic [7:0] pl_q[$];
    bit         busy_script[$];
    bit         valid_script[$];

    logic [12:0] obs;
    assign obs = {data_out, pkt_valid, payload_ready, tx_active, done, err};

    router_pkt_tx #(.GAP_CYCLES(GAP)) dut (
        .clock         (clock),
        .reset         (reset),
        .start         (start),
        .dest_addr     (dest_addr),
        .payload_len   (payload_len),
        .payload_data  (payload_data),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .busy          (busy),
        .data_out      (data_out),
        .pkt_valid     (pkt_valid),
        .tx_active     (tx_active),
        .done          (done),
        .err           (err)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge clock);
    endtask

    // Drives one packet through load, transmit and gap, checking every cycle
    // against the expected byte list {header, payload..., xor of all}.
    task automatic send_packet(input logic [1:0] addr, input int len,
                               input int valid_pct, input int busy_pct,
                               input bit stray_start);
        logic [7:0]  exp_q[$];
        logic [7:0]  par;
        logic [12:0] expv;
        logic [4:0]  exp5;
        int          accepted;
        int          idx;
        int          guard;
        bit          v;
        bit          b;

        par = {6'(len), addr};
        exp_q.push_back(par);
        foreach (pl_q[i]) begin
            exp_q.push_back(pl_q[i]);
            par = par ^ pl_q[i];
        end
        exp_q.push_back(par);

        start = 1'b1; dest_addr = addr; payload_len = 6'(len);
        step();
        start = 1'b0;
        vectors++;
        if (obs[4:0] !== 5'b01100) begin
            miscompares++;
            $display("FAIL enter_load: got %b expected %b", obs[4:0], 5'b01100);
        end

        accepted = 0;
        guard = 0;
        while (accepted < len && guard < 2000) begin
            if (valid_script.size() > 0) v = valid_script.pop_front();
            else                         v = ($urandom_range(99) < valid_pct);
            payload_valid = v;
            payload_data  = v ? pl_q[accepted] : 8'($urandom);
            if (stray_start) begin
                start = 1'($urandom_range(1)); dest_addr = 2'($urandom_range(2));
                payload_len = 6'($urandom_range(1, 63));
            end
            step();
            if (v) accepted++;
            guard++;
            vectors++;
            exp5 = {accepted >= len, accepted < len, 1'b1, 1'b0, 1'b0};
            if (obs[4:0] !== exp5) begin
                miscompares++;
                $display("FAIL load_accept[%0d]: got %b expected %b", accepted, obs[4:0], exp5);
            end
        end
        payload_valid = 1'b0;
        if (accepted < len) begin
            vectors++; miscompares++;
            $display("FAIL load_timeout: got %0d bytes expected %0d", accepted, len);
        end

        idx = 0;
        guard = 0;
        while (idx < len + 2 && guard < 5000) begin
            vectors++;
            expv = {exp_q[idx], idx <= len, 1'b0, 1'b1, 1'b0, 1'b0};
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL out_byte[%0d]: got %h expected %h", idx, obs, expv);
            end
            if (busy_script.size() > 0) b = busy_script.pop_front();
            else                        b = ($urandom_range(99) < busy_pct);
            busy = b;
            if (stray_start) begin
                start = 1'($urandom_range(1)); dest_addr = 2'($urandom_range(2));
                payload_len = 6'($urandom_range(1, 63));
            end
            step();
            if (!b) idx++;
            guard++;
        end
        if (idx < len + 2) begin
            vectors++; miscompares++;
            $display("FAIL tx_timeout: got %0d bytes expected %0d", idx, len + 2);
        end

        for (int g = 0; g < GAP; g++) begin
            vectors++;
            expv = {8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL gap[%0d]: got %h expected %h", g, obs, expv);
            end
            busy = 1'($urandom_range(1));
            step();
        end
        start = 1'b0;
        busy  = 1'b0;
        vectors++;
        expv = {8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        if (obs !== expv) begin
            miscompares++;
            $display("FAIL done_pulse: got %h expected %h", obs, expv);
        end
        step();
        vectors++;
        if (obs !== 13'h0) begin
            miscompares++;
            $display("FAIL post_done_idle: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        vectors++;
        if (obs !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected %h", obs, 13'h0);
        end
        reset = 1'b0;
        step();
        vectors++;
        if (obs !== 13'h0) begin
            miscompares++;
            $display("FAIL idle_after_reset: got %h expected %h", obs, 13'h0);
        end
    endtask

    task automatic test_basic();
        pl_q = '{8'hAA, 8'h55, 8'h0F};
        send_packet(2'd1, 3, 100, 0, 1'b0);
    endtask

    task automatic test_busy_hold();
        pl_q = '{8'hAA, 8'h55, 8'h0F};
        busy_script = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        send_packet(2'd1, 3, 100, 0, 1'b0);
    endtask

    task automatic test_err();
        logic [1:0] addrs[2];
        logic [5:0] lens[2];
        logic [12:0] expv;
        addrs = '{2'd1, 2'd3};
        lens  = '{6'd0, 6'd4};
        for (int k = 0; k < 2; k++) begin
            start = 1'b1; dest_addr = addrs[k]; payload_len = lens[k];
            step();
            start = 1'b0;
            vectors++;
            expv = {8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
            if (obs !== expv) begin
                miscompares++;
                $display("FAIL err_pulse[%0d]: got %h expected %h", k, obs, expv);
            end
            step();
            vectors++;
            if (obs !== 13'h0) begin
                miscompares++;
                $display("FAIL err_cleared[%0d]: got %h expected %h", k, obs, 13'h0);
            end
        end
    endtask

    task automatic test_valid_toggle();
        pl_q = '{8'h3C, 8'hC3, 8'h81};
        valid_script = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        send_packet(2'd0, 3, 0, 0, 1'b0);
    endtask

    task automatic test_reset_mid_packet();
        start = 1'b1; dest_addr = 2'd0; payload_len = 6'd63;
        step();
        start = 1'b0;
        payload_valid = 1'b1;
        for (int i = 0; i < 63; i++) begin
            payload_data = 8'($urandom);
            step();
        end
        payload_valid = 1'b0;
        busy = 1'b0;
        for (int i = 0; i < 6; i++) step();
        vectors++;
        if ({pkt_valid, tx_active} !== 2'b11) begin
            miscompares++;
            $display("FAIL mid_payload: got %b expected %b", {pkt_valid, tx_active}, 2'b11);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        vectors++;
        if (obs !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_mid_packet: got %h expected %h", obs, 13'h0);
        end
        pl_q = '{8'h01};
        send_packet(2'd2, 1, 100, 0, 1'b0);
    endtask

    task automatic test_random();
        int len;
        for (int p = 0; p < 20; p++) begin
            len = (p % 4 == 0) ? 63 : int'($urandom_range(1, 12));
            pl_q = {};
            for (int i = 0; i < len; i++) pl_q.push_back(8'($urandom));
            send_packet(2'($urandom_range(2)), len, int'($urandom_range(40, 100)),
                        int'($urandom_range(0, 60)), 1'b1);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; dest_addr = '0; payload_len = '0;
        payload_data = '0; payload_valid = 1'b0; busy = 1'b0;
        step();
        test_reset();
        test_basic();
        test_busy_hold();
        test_err();
        test_valid_toggle();
        test_reset_mid_packet();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/router_pkt_tx.md
ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

Interface
REQ-001 SHALL have parameter GAP_CYCLES, default 3, meaning idle cycles inserted after each parity byte before the next header.
REQ-002 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  request to send one packet, sampled only in IDLE.
REQ-005 SHALL have port dest_addr  input  2  destination port 0..2, captured with start.
REQ-006 SHALL have port payload_len  input  6  payload byte count 1..63, captured with start.
REQ-007 SHALL have port payload_data  input  8  payload byte from the upstream source.
REQ-008 SHALL have port payload_valid  input  1  payload_data is valid.
REQ-009 SHALL have port payload_ready  output  1  block accepts payload_data this cycle.
REQ-010 SHALL have port busy  input  1  router stall: the byte on data_out is not consumed this cycle.
REQ-011 SHALL have port data_out  output  8  byte driven to the router data_in.
REQ-012 SHALL have port pkt_valid  output  1  high for header and payload bytes, low for parity byte and idle.
REQ-013 SHALL have port tx_active  output  1  high in every state except IDLE.
REQ-014 SHALL have port done  output  1  one-cycle pulse when the GAP state completes.
REQ-015 SHALL have port err  output  1  one-cycle pulse when start is rejected.

Function
REQ-016 SHALL implement states IDLE, LOAD, HEADER, PAYLOAD, PARITY, GAP; all outputs registered.
REQ-017 IDLE: start with payload_len!=0 and dest_addr!=2'b11 SHALL latch header = {payload_len, dest_addr}, clear byte count, set parity = header, go to LOAD next cycle.
REQ-018 IDLE: start with payload_len==0 or dest_addr==2'b11 SHALL pulse err for one cycle and remain in IDLE.
REQ-019 start outside IDLE SHALL be ignored.
REQ-020 LOAD: payload_ready=1; each cycle with payload_valid=1 SHALL write payload_data to buffer[count], XOR it into parity, increment count.
REQ-021 LOAD SHALL go to HEADER on the cycle the payload_len-th byte is accepted; payload_ready SHALL be 0 in every other state.
REQ-022 HEADER: data_out=header, pkt_valid=1; advance to PAYLOAD on a cycle with busy=0, else hold data_out and pkt_valid unchanged.
REQ-023 PAYLOAD: data_out=buffer[index], pkt_valid=1, index advances only on busy=0; after the last byte is consumed go to PARITY.
REQ-024 Payload bytes SHALL be presented back-to-back in load order with no bubble when busy=0.
REQ-025 PARITY: data_out=parity (XOR of header and all payload bytes), pkt_valid=0; advance to GAP on busy=0.
REQ-026 GAP: data_out=0, pkt_valid=0, busy ignored; after GAP_CYCLES cycles pulse done and return to IDLE.
REQ-027 Byte index and count SHALL be 6 bits; no wrap occurs because payload_len is at most 63.

Reset
REQ-028 reset high at a clock edge SHALL force IDLE, data_out=8'h00, pkt_valid=0, payload_ready=0, tx_active=0, done=0, err=0, parity, count and index to 0, from any state including mid-packet.
REQ-029 Buffer contents SHALL NOT require reset.

Structure
REQ-030 State encoding, HDR_W=8, LEN_W=6, ADDR_INVALID=2'b11 SHALL reside in shared package router_pkg.
REQ-031 Payload storage SHALL be sub-module router_pkt_buf: 64x8, one write port, one asynchronous read port, no reset.

Verification
REQ-032 start, addr=1, len=3, payload AA,55,0F, busy=0 -> data_out 0D,AA,55,0F with pkt_valid=1, then FD with pkt_valid=0, done 4 cycles after parity.
REQ-033 Same packet with busy=1 for 2 cycles during byte 55 -> 55 held stable 3 cycles, sequence and parity FD unchanged.
REQ-034 start with len=0, and separately addr=3 -> err pulses once each, tx_active stays 0, no bytes sent.
REQ-035 payload_valid toggled 1,0,1,0,1 in LOAD -> exactly 3 bytes stored, HEADER entered after third accept.
REQ-036 reset asserted during PAYLOAD of a len=63 packet -> next cycle IDLE, pkt_valid=0, data_out=00; a following packet with addr=2, len=1, payload 01 sends 06,01,07.
